// File: rtl/clksw_ctl.sv
// Sequencer for a two-source glitch-free clock switch: enables the target
// oscillator, waits for ready and settle, drives sel, confirms the hand-over.
// Build option: define CLKSW_CTL_GATE_OFF_EN to disable the old oscillator after a switch.
module clksw_ctl #(
  parameter logic INIT     = 1'b0,
  parameter int   SETTLE_W = 8,
  parameter int   SETTLE   = 100,
  parameter int   TMO_W    = 12,
  parameter int   TMO      = 2000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       req,
  input  logic [1:0] rdy,
  input  logic [1:0] vld,
  output logic [1:0] en_src,
  output logic       sel,
  output logic       cur,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENABLE = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SWITCH = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ABORT  = 3'd5;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TMO - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic                tgt;
  logic                err_lock;
  logic [1:0]          rdy_p0;
  logic [1:0]          rdy_p1;
  logic [1:0]          vld_p0;
  logic [1:0]          vld_p1;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tgt_rdy;
  logic [1:0]          tgt_hot;
  logic                tmo_hit;
  logic                settle_hit;

  function automatic logic [SETTLE_W-1:0] settle_inc(input logic [SETTLE_W-1:0] c);
    return (&c) ? c : c + SETTLE_W'(1);
  endfunction

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] c);
    return (&c) ? c : c + TMO_W'(1);
  endfunction

  assign tgt_rdy    = rdy_p1[tgt];
  assign tgt_hot    = {tgt, ~tgt};
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign settle_hit = (settle_cnt == SETTLE_LAST);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = (state == S_ABORT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req != cur && !err_lock) state_nxt = S_ENABLE;
      S_ENABLE: begin
        if (tgt_rdy)      state_nxt = S_SETTLE;
        else if (tmo_hit) state_nxt = S_ABORT;
      end
      S_SETTLE: begin
        if (!tgt_rdy)        state_nxt = S_ENABLE;
        else if (settle_hit) state_nxt = S_SWITCH;
      end
      // An all-zero vld is the switch's normal mid-hand-over gap, not a fault.
      S_SWITCH: begin
        if (vld_p1 == tgt_hot)       state_nxt = S_DONE;
        else if (!tgt_rdy || tmo_hit) state_nxt = S_ABORT;
      end
      S_DONE:   state_nxt = S_IDLE;
      S_ABORT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdy_p0     <= 2'b00;
      rdy_p1     <= 2'b00;
      vld_p0     <= 2'b00;
      vld_p1     <= 2'b00;
      state      <= S_IDLE;
      tgt        <= INIT;
      err_lock   <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      sel        <= INIT;
      cur        <= INIT;
      en_src     <= {INIT, ~INIT};
    end else begin
      // p0 -> p1: two-flop synchronisers for the asynchronous status flags
      rdy_p0 <= rdy;
      rdy_p1 <= rdy_p0;
      vld_p0 <= vld;
      vld_p1 <= vld_p0;

      state   <= state_nxt;
      tmo_cnt <= (state_nxt != state) ? '0 : tmo_inc(tmo_cnt);
      if (state != S_SETTLE)
        settle_cnt <= '0;
      else if (tgt_rdy)
        settle_cnt <= settle_inc(settle_cnt);

      case (state)
        S_IDLE: begin
          if (req == cur) begin
            err_lock <= 1'b0;
          end else if (!err_lock) begin
            tgt         <= req;
            en_src[req] <= 1'b1;
          end
        end
        S_SETTLE: if (state_nxt == S_SWITCH) sel <= tgt;
        S_DONE: begin
          cur <= tgt;
`ifdef CLKSW_CTL_GATE_OFF_EN
          en_src <= tgt_hot;
`endif
        end
        // The confirmed source is never touched, so en_src cannot reach 2'b00.
        S_ABORT: begin
          sel         <= cur;
          en_src[tgt] <= 1'b0;
          err_lock    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clksw_ctl.sv
// Bench for clksw_ctl: directed scenarios plus random rdy/req/vld traffic,
// every cycle compared against a procedural reference sequencer.
module tb_clksw_ctl;

  localparam int SETTLE = 4;
  localparam int TMO    = 16;
`ifdef CLKSW_CTL_GATE_OFF_EN
  localparam logic [1:0] EN_AFTER = 2'b10;
`else
  localparam logic [1:0] EN_AFTER = 2'b11;
`endif

  logic       clk  = 1'b0;
  logic       rstb = 1'b1;
  logic       req  = 1'b0;
  logic [1:0] rdy  = 2'b00;
  logic [1:0] vld  = 2'b01;
  logic [1:0] en_src;
  logic       sel, cur, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_errp   = 0;

  // clock-switch emulator state
  bit   stuck     = 1'b0;
  bit   glitch_en = 1'b0;
  int   e_dly     = 2;
  int   e_t       = 1000;
  logic e_sel     = 1'b0;

  // reference model state
  logic       m_sel, m_cur, m_busy, m_done, m_err;
  logic [1:0] m_en;
  bit         lock, killed;
  logic [1:0] rh1, rh2, vh1, vh2;

  clksw_ctl #(.INIT(1'b0), .SETTLE_W(8), .SETTLE(SETTLE), .TMO_W(12), .TMO(TMO)) dut (
    .clk(clk), .rstb(rstb), .req(req), .rdy(rdy), .vld(vld),
    .en_src(en_src), .sel(sel), .cur(cur), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] hot(input logic s);
    return {s, ~s};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_sel = 1'b0; m_cur = 1'b0; m_en = 2'b01; m_busy = 1'b0;
    m_done = 1'b0; m_err = 1'b0; lock = 1'b0;
    rh1 = 2'b00; rh2 = 2'b00; vh1 = 2'b00; vh2 = 2'b00;
  endtask

  // One controller clock: returns the synchronised flags seen at this edge.
  task automatic tick(output logic [1:0] rs, output logic [1:0] vs);
    @(posedge clk or negedge rstb);
    rs = rh2;
    vs = vh2;
    if (!rstb) begin
      killed = 1'b1;
      return;
    end
    rh2 = rh1; vh2 = vh1; rh1 = rdy; vh1 = vld;
  endtask

  task automatic finish_attempt(input logic t, input bit ok);
    logic [1:0] rs, vs;
    if (ok) m_done = 1'b1; else m_err = 1'b1;
    tick(rs, vs);
    if (killed) return;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_busy = 1'b0;
    if (ok) begin
      m_cur = t;
`ifdef CLKSW_CTL_GATE_OFF_EN
      m_en = hot(t);
`endif
    end else begin
      m_sel   = m_cur;
      m_en[t] = 1'b0;
      lock    = 1'b1;
    end
  endtask

  task automatic attempt(input logic t);
    logic [1:0] rs, vs;
    bit got, settled, ok;
    int k;
    settled = 1'b0;
    while (!settled) begin
      got = 1'b0;
      for (int n = 0; n < TMO; n++) begin
        tick(rs, vs);
        if (killed) return;
        if (rs[t]) begin got = 1'b1; break; end
      end
      if (!got) begin finish_attempt(t, 1'b0); return; end
      k = 0;
      forever begin
        tick(rs, vs);
        if (killed) return;
        if (!rs[t]) break;
        if (k == SETTLE - 1) begin settled = 1'b1; break; end
        k++;
      end
    end
    m_sel = t;
    ok = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      tick(rs, vs);
      if (killed) return;
      if (vs == hot(t)) begin ok = 1'b1; break; end
      if (!rs[t]) break;
    end
    finish_attempt(t, ok);
  endtask

  initial begin
    logic [1:0] rs, vs;
    logic t;
    model_reset();
    forever begin
      wait (rstb === 1'b1);
      killed = 1'b0;
      while (!killed) begin
        tick(rs, vs);
        if (killed) break;
        if (req == m_cur) lock = 1'b0;
        else if (!lock) begin
          t       = req;
          m_en[t] = 1'b1;
          m_busy  = 1'b1;
          attempt(t);
        end
      end
      model_reset();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic emulate_switch();
    if (!rstb) begin
      e_sel = 1'b0; e_t = 1000; vld = 2'b01;
      return;
    end
    if (sel !== e_sel) begin e_sel = sel; e_t = 0; end
    else if (e_t < 1000) e_t++;
    if (!stuck) begin
      if (e_t == 1) vld = 2'b00;
      else if (e_t == 1 + e_dly) vld = hot(e_sel);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("sel", 32'(sel), 32'(m_sel));
    check("cur", 32'(cur), 32'(m_cur));
    check("en_src", 32'(en_src), 32'(m_en));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_errp++;
    emulate_switch();
  endtask

  task automatic do_reset(input logic [1:0] r);
    rstb = 1'b0; req = 1'b0; rdy = r; stuck = 1'b0; glitch_en = 1'b0; e_dly = 2;
    repeat (3) cyc();
    rstb = 1'b1;
    repeat (4) cyc();
    n_done = 0;
    n_errp = 0;
  endtask

  // Cycles from the req change until sel (or err) is first seen high; -1 if never.
  task automatic wait_evt(input bit on_err, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      if (glitch_en && i == 2) rdy[1] = 1'b0;
      if (glitch_en && i == 3) rdy[1] = 1'b1;
      if ((on_err ? err : sel) === 1'b1) begin lat = i; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, nbusy;
    #1 rstb = 1'b0;
    req = 1'b1;
    repeat (10) begin
      cyc();
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_cur", 32'(cur), 32'd0);
      check("rst_en", 32'(en_src), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    req = 1'b0;

    // normal switch 0 -> 1
    do_reset(2'b11);
    req = 1'b1;
    wait_evt(1'b0, 40, lat);
    check("norm_sel_lat", lat, 6);
    repeat (12) cyc();
    check("norm_done_cnt", n_done, 1);
    check("norm_cur", 32'(cur), 32'd1);
    check("norm_en", 32'(en_src), 32'(EN_AFTER));
    check("norm_busy", 32'(busy), 32'd0);

    // one-cycle ready glitch during settle
    do_reset(2'b11);
    glitch_en = 1'b1;
    req = 1'b1;
    wait_evt(1'b0, 40, lat);
    glitch_en = 1'b0;
    check("glitch_sel_lat", lat, 10);
    repeat (12) cyc();
    check("glitch_done_cnt", n_done, 1);

    // ready timeout, lock, and retry after req returns
    do_reset(2'b01);
    req = 1'b1;
    wait_evt(1'b1, 40, lat);
    check("rdy_tmo_lat", lat, 17);
    cyc();
    check("rdy_tmo_en", 32'(en_src), 32'd1);
    check("rdy_tmo_sel", 32'(sel), 32'd0);
    nbusy = 0;
    repeat (10) begin cyc(); if (busy === 1'b1) nbusy++; end
    check("rdy_tmo_noretry", nbusy, 0);
    check("rdy_tmo_err_cnt", n_errp, 1);
    req = 1'b0;
    repeat (2) cyc();
    req = 1'b1;
    cyc();
    check("rdy_tmo_retry", 32'(busy), 32'd1);
    repeat (20) cyc();

    // valid stuck at the old source
    do_reset(2'b11);
    stuck = 1'b1;
    req = 1'b1;
    wait_evt(1'b1, 60, lat);
    check("vld_tmo_lat", lat, 22);
    cyc();
    check("vld_tmo_sel", 32'(sel), 32'd0);
    check("vld_tmo_cur", 32'(cur), 32'd0);
    check("vld_tmo_en", 32'(en_src), 32'd1);

    // asynchronous reset while in SWITCH
    do_reset(2'b11);
    stuck = 1'b1;
    req = 1'b1;
    wait_evt(1'b0, 40, lat);
    check("rst_mid_sel_lat", lat, 6);
    repeat (2) cyc();
    #2 rstb = 1'b0;
    #1;
    check("rst_mid_sel", 32'(sel), 32'd0);
    check("rst_mid_cur", 32'(cur), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_en", 32'(en_src), 32'd1);
    req = 1'b0;
    stuck = 1'b0;
    n_done = 0;
    n_errp = 0;
    repeat (3) cyc();
    rstb = 1'b1;
    repeat (10) cyc();
    check("rst_mid_pulses", n_done + n_errp, 0);

    // random traffic
    for (int ep = 0; ep < 40; ep++) begin
      if ($urandom_range(0, 2) == 0) do_reset(2'($urandom_range(0, 3)));
      stuck = ($urandom_range(0, 5) == 0);
      e_dly = $urandom_range(1, 4);
      for (int c = 0; c < 60; c++) begin
        cyc();
        if (!rstb) rstb = 1'b1;
        else if ($urandom_range(0, 299) == 0) rstb = 1'b0;
        if ($urandom_range(0, 19) == 0) req = ~req;
        if ($urandom_range(0, 15) == 0) rdy[0] = ~rdy[0];
        if ($urandom_range(0, 11) == 0) rdy[1] = ~rdy[1];
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
